// File: rtl/switch_out_buffer_80_if.sv
// Port bundle for the 80-bit switch output buffer: allocator-facing write side and link-facing read side.
// Write side: a flit is taken on an edge where VALID_in=1 and busy_out=0; otherwise the allocator holds it.
// Read side: the head flit is consumed on an edge where VALID_out=1 and BWDAUX1_in=0 (stall=0).
interface switch_out_buffer_80_if #(
  parameter int FLIT_W = 80,
  parameter int DEPTH  = 4,
  parameter int OCC_W  = $clog2(DEPTH) + 1
);
  logic [FLIT_W-1:0] FLIT_in;
  logic              VALID_in;
  logic              FWDAUX1_in;
  logic              shift_ctl;
  logic              busy_out;
  logic [FLIT_W-1:0] FLIT_out;
  logic              VALID_out;
  logic              FWDAUX1_out;
  logic              BWDAUX1_in;
  logic [OCC_W-1:0]  occupancy;

  modport master (
    output FLIT_in, VALID_in, FWDAUX1_in, shift_ctl, BWDAUX1_in,
    input  busy_out, FLIT_out, VALID_out, FWDAUX1_out, occupancy
  );

  modport slave (
    input  FLIT_in, VALID_in, FWDAUX1_in, shift_ctl, BWDAUX1_in,
    output busy_out, FLIT_out, VALID_out, FWDAUX1_out, occupancy
  );
endinterface

// File: rtl/switch_out_buffer_80.sv
// Output-side elastic FIFO of a NoC switch port: captures granted flits, optionally trims one
// route hop on write, and drives the link with stall/go flow control.
module switch_out_buffer_80 #(
  parameter int FLIT_W  = 80,
  parameter int FTYPE_W = 2,
  parameter int PORT_W  = 3,
  parameter int DEPTH   = 4
) (
  input logic clk,
  input logic rst,
  switch_out_buffer_80_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int HI = FTYPE_W + PORT_W;

  logic [FLIT_W:0]   mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              full;
  logic              not_empty;
  logic              wr;
  logic              rd;
  logic [FLIT_W-1:0] wr_flit;
  logic [FLIT_W:0]   head;

  // busy is decoded from the registered count only, so no input reaches it combinationally
  assign full      = (count == CW'(DEPTH));
  assign not_empty = (count != '0);
  assign wr        = bus.VALID_in & ~full;
  assign rd        = not_empty & ~bus.BWDAUX1_in;

  // Hop trim keeps the type field, drops the consumed hop and zero-fills the MSBs
  always_comb begin
    wr_flit = bus.FLIT_in;
    if (bus.shift_ctl)
      wr_flit = {{PORT_W{1'b0}}, bus.FLIT_in[FLIT_W-1:HI], bus.FLIT_in[FTYPE_W-1:0]};
  end

  // Storage needs no reset: every output is gated by not_empty
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= {bus.FWDAUX1_in, wr_flit};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head            = mem[rd_ptr];
  assign bus.busy_out    = full;
  assign bus.VALID_out   = not_empty;
  assign bus.FLIT_out    = not_empty ? head[FLIT_W-1:0] : '0;
  assign bus.FWDAUX1_out = not_empty & head[FLIT_W];
  assign bus.occupancy   = count;
endmodule

// File: tb/tb_switch_out_buffer_80.sv
// Directed-plus-random bench for switch_out_buffer_80 checked against a queue-based reference.
module tb_switch_out_buffer_80;
  localparam int FLIT_W  = 80;
  localparam int FTYPE_W = 2;
  localparam int PORT_W  = 3;
  localparam int DEPTH   = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [FLIT_W:0] exp_q[$];

  switch_out_buffer_80_if #(.FLIT_W(FLIT_W), .DEPTH(DEPTH)) bus_if ();

  switch_out_buffer_80 #(
    .FLIT_W(FLIT_W), .FTYPE_W(FTYPE_W), .PORT_W(PORT_W), .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference trim: drop the hop by arithmetic on the route part, keep the type bits
  function automatic logic [FLIT_W-1:0] trim(input logic [FLIT_W-1:0] f);
    logic [FLIT_W-1:0] route;
    logic [FLIT_W-1:0] ftype;
    route = (f >> (FTYPE_W + PORT_W)) << FTYPE_W;
    ftype = f % (1 << FTYPE_W);
    return route | ftype;
  endfunction

  function automatic logic [FLIT_W-1:0] rand_flit();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[FLIT_W-1:0];
  endfunction

  task automatic check_outputs(input string tag);
    logic [FLIT_W:0] e;
    int n;
    n = exp_q.size();
    e = (n != 0) ? exp_q[0] : '0;
    chk({tag, "_valid"}, 96'(bus_if.VALID_out), 96'(n != 0));
    chk({tag, "_flit"},  96'(bus_if.FLIT_out), 96'(e[FLIT_W-1:0]));
    chk({tag, "_aux"},   96'(bus_if.FWDAUX1_out), 96'(e[FLIT_W]));
    chk({tag, "_busy"},  96'(bus_if.busy_out), 96'(n == DEPTH));
    chk({tag, "_occ"},   96'(bus_if.occupancy), 96'(n));
  endtask

  // Driver: called at a falling edge; applies inputs, advances the model across one rising edge
  task automatic step(input string tag, input logic v, input logic [FLIT_W-1:0] f,
                      input logic a, input logic s, input logic st);
    logic            do_wr;
    logic            do_rd;
    logic [FLIT_W:0] ent;
    logic            prev_v;
    logic [FLIT_W-1:0] prev_f;
    bus_if.VALID_in   = v;
    bus_if.FLIT_in    = f;
    bus_if.FWDAUX1_in = a;
    bus_if.shift_ctl  = s;
    bus_if.BWDAUX1_in = st;
    do_wr  = v && (exp_q.size() < DEPTH);
    do_rd  = (exp_q.size() != 0) && !st;
    ent    = {a, s ? trim(f) : f};
    prev_v = bus_if.VALID_out;
    prev_f = bus_if.FLIT_out;
    @(posedge clk);
    if (do_rd) void'(exp_q.pop_front());
    if (do_wr) exp_q.push_back(ent);
    @(negedge clk);
    check_outputs(tag);
    if (prev_v && st) chk({tag, "_stall_hold"}, 96'(bus_if.FLIT_out), 96'(prev_f));
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus_if.VALID_in   = 1'b0;
    bus_if.FLIT_in    = '0;
    bus_if.FWDAUX1_in = 1'b0;
    bus_if.shift_ctl  = 1'b0;
    bus_if.BWDAUX1_in = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs("reset");
    rst = 1'b0;
    idle("idle");

    // Single head flit with hop trim: type=11, hop=010
    step("single", 1'b1, {72'h1234_5678_9ABC_DEF0_12, 8'h2B}, 1'b1, 1'b1, 1'b0);
    chk("single_type", 96'(bus_if.FLIT_out[1:0]), 96'(2'b11));
    idle("single_gone");

    // Fill under stall, then a fifth offer is ignored
    for (int i = 0; i < DEPTH; i++)
      step("fill", 1'b1, rand_flit(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    step("fill_ovf", 1'b1, rand_flit(), 1'b1, 1'b0, 1'b1);

    // Drain from full with VALID_in held high
    for (int i = 0; i < 8; i++)
      step("drain", 1'b1, rand_flit(), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    while (exp_q.size() != 0) idle("drain_empty");

    // Random streaming with random stalls
    for (int i = 0; i < 20; i++)
      step("stream", 1'b1, rand_flit(), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 12; i++)
      step("stream_rand", 1'($urandom_range(0, 1)), rand_flit(), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0));
    while (exp_q.size() != 0) idle("stream_empty");

    // Pointer wrap: hold occupancy at 2 while writing and reading together
    step("wrap_pre", 1'b1, rand_flit(), 1'b0, 1'b0, 1'b1);
    step("wrap_pre", 1'b1, rand_flit(), 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++)
      step("wrap", 1'b1, rand_flit(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    while (exp_q.size() != 0) idle("wrap_empty");

    // Stall while empty has no effect
    step("empty_stall", 1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Reset mid-operation drops the queue immediately
    step("prerst", 1'b1, rand_flit(), 1'b1, 1'b0, 1'b1);
    step("prerst", 1'b1, rand_flit(), 1'b1, 1'b0, 1'b1);
    bus_if.VALID_in = 1'b0;
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    check_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    idle("postrst");
    step("postrst_wr", 1'b1, rand_flit(), 1'b0, 1'b0, 1'b0);
    idle("postrst_rd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
